// File: rtl/fifo_read_arbiter_if.sv
// Read-side bundle between the arbiter, its consumers and the FIFO read port.
// Latency: none (wires only).
// Backpressure: consumers throttle by dropping req; FIFO throttles via fifo_empty.
interface fifo_read_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0] req;
  logic            fifo_empty;
  logic [DW-1:0]   fifo_dout;
  logic            fifo_rd_en;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rd_valid;
  logic [DW-1:0]   rd_data;
  logic            busy;

  // Arbiter side.
  modport master (
    input  req, fifo_empty, fifo_dout,
    output fifo_rd_en, gnt, rd_valid, rd_data, busy
  );

  // Consumer / FIFO side.
  modport slave (
    output req, fifo_empty, fifo_dout,
    input  fifo_rd_en, gnt, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Round-robin sharing of one FIFO read port among NREQ consumers, bounded bursts.
// Latency: grant 1 cycle after request; read data/valid 1 cycle after fifo_rd_en.
// Backpressure: reads stop combinationally on req drop or fifo_empty; one idle cycle between grants.
module fifo_read_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  fifo_read_arbiter_if.master bus
);
  localparam int CW = $clog2(BURST) + 1;
  localparam int LW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   last;
  logic [LW-1:0]   gidx;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rd_valid_q;
  logic            win_vld;
  logic [LW-1:0]   win_idx;
  logic            rd_en;
  logic            burst_end;

  // Pick the first requester after the last winner; descending scan so the nearest one wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      logic [LW-1:0] idx;
      idx = LW'((int'(last) + i) % NREQ);
      if (bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Next state plus the combinational read strobe and burst termination.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    burst_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_vld && !bus.fifo_empty) state_nxt = S_BURST;
      end
      S_BURST: begin
        rd_en     = bus.req[gidx] && !bus.fifo_empty;
        burst_end = (rd_en && (cnt == CW'(BURST - 1))) || !bus.req[gidx] || bus.fifo_empty;
        if (burst_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Grant, beat counter and round-robin pointer; last starts at NREQ-1 so consumer 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= '0;
      gidx  <= '0;
      cnt   <= '0;
      last  <= LW'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (state_nxt == S_BURST) begin
            gnt_q <= ONE << win_idx;
            gidx  <= win_idx;
            cnt   <= '0;
          end
        end
        S_BURST: begin
          if (burst_end) begin
            gnt_q <= '0;
            last  <= gidx;
            cnt   <= '0;
          end else if (rd_en) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: gnt_q <= '0;
      endcase
    end
  end

  // Data strobe follows the read by one cycle, so the final beat lands in the idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid_q <= '0;
    else        rd_valid_q <= rd_en ? gnt_q : '0;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.gnt        = gnt_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = bus.fifo_dout;
  assign bus.busy       = (state == S_BURST);
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: table vectors, directed corner sequences, random traffic vs reference model.
// Latency: n/a.
// Backpressure: the bench models the FIFO read side as a queue with a registered read output.
module tb_fifo_read_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_read_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_read_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO contents; written values are a running sequence so the nth read must return value n.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_seq = '0;
  logic [DW-1:0] rd_seq = '0;

  // Reference model: who owns the port, beats taken, last winner, data strobe due this cycle.
  int              m_owner = -1;
  int              m_last  = NREQ - 1;
  int              m_beats = 0;
  logic [NREQ-1:0] m_vld   = '0;
  logic [DW-1:0]   m_dat   = '0;

  // Samples taken mid-cycle by tick().
  logic [NREQ-1:0] s_gnt, s_rd_valid;
  logic            s_rd_en, s_busy, s_empty;
  logic [DW-1:0]   s_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_at(input logic [NREQ-1:0] v, input int k);
    logic [NREQ-1:0] sh;
    sh = v >> k;
    return sh[0];
  endfunction

  task automatic push(input int n);
    repeat (n) begin
      fifo_q.push_back(wr_seq);
      wr_seq++;
    end
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic flush();
    fifo_q.delete();
    rd_seq = wr_seq;
    bus.fifo_empty = 1'b1;
  endtask

  // One clock cycle: apply inputs, check mid-cycle against the model, advance model and FIFO at the edge.
  task automatic tick(input logic [NREQ-1:0] r, input int n_push);
    logic [NREQ-1:0] e_gnt;
    logic            e_rd_en;
    logic            emp;
    bit              found;
    int              k;
    bus.req = r;
    push(n_push);
    @(negedge clk);
    emp        = bus.fifo_empty;
    s_gnt      = bus.gnt;
    s_rd_en    = bus.fifo_rd_en;
    s_rd_valid = bus.rd_valid;
    s_busy     = bus.busy;
    s_empty    = emp;
    s_dat      = bus.rd_data;
    e_gnt   = (m_owner >= 0) ? (ONE << m_owner) : '0;
    e_rd_en = (m_owner >= 0) && bit_at(r, m_owner) && !emp;
    chk("model_gnt", 32'(s_gnt), 32'(e_gnt));
    chk("model_rd_en", 32'(s_rd_en), 32'(e_rd_en));
    chk("model_busy", 32'(s_busy), 32'(m_owner >= 0));
    chk("model_rd_valid", 32'(s_rd_valid), 32'(m_vld));
    if (m_vld != '0) chk("model_rd_data", 32'(s_dat), 32'(m_dat));
    // Advance the model across the edge.
    m_vld = e_rd_en ? e_gnt : '0;
    if (e_rd_en) begin
      m_dat = rd_seq;
      rd_seq++;
    end
    if (m_owner < 0) begin
      if (r != '0 && !emp) begin
        found = 0;
        for (int i = 1; i <= NREQ; i++) begin
          k = (m_last + i) % NREQ;
          if (!found && bit_at(r, k)) begin
            found   = 1;
            m_owner = k;
          end
        end
        m_beats = 0;
      end
    end else begin
      if (e_rd_en) m_beats++;
      if (m_beats == BURST || !bit_at(r, m_owner) || emp) begin
        m_last  = m_owner;
        m_owner = -1;
        m_beats = 0;
      end
    end
    @(posedge clk);
    #1;
    if (s_rd_en && fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  // Asynchronous reset from mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    m_owner = -1;
    m_last  = NREQ - 1;
    m_beats = 0;
    m_vld   = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    int              push;
    logic [NREQ-1:0] gnt;
    logic            rd_en;
    logic [NREQ-1:0] rd_valid;
    logic            busy;
    int              didx;
  } vec_t;

  vec_t          tbl[7];
  logic [DW-1:0] base;
  int            cnt_rd, cnt_v0;
  logic [NREQ-1:0] exp_g;
  logic [NREQ-1:0] cur_req;

  initial begin
    bus.req        = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;

    // Reset values while rst_n is held from time zero.
    #2;
    chk("init_gnt", 32'(bus.gnt), 32'd0);
    chk("init_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("init_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("init_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single burst of four from a 10-entry FIFO, then regrant after one idle cycle.
    flush();
    base = rd_seq;
    tbl[0] = '{4'b0001, 10, 4'b0000, 1'b0, 4'b0000, 1'b0, -1};
    tbl[1] = '{4'b0001, 0,  4'b0001, 1'b1, 4'b0000, 1'b1, -1};
    tbl[2] = '{4'b0001, 0,  4'b0001, 1'b1, 4'b0001, 1'b1, 0};
    tbl[3] = '{4'b0001, 0,  4'b0001, 1'b1, 4'b0001, 1'b1, 1};
    tbl[4] = '{4'b0001, 0,  4'b0001, 1'b1, 4'b0001, 1'b1, 2};
    tbl[5] = '{4'b0001, 0,  4'b0000, 1'b0, 4'b0001, 1'b0, 3};
    tbl[6] = '{4'b0001, 0,  4'b0001, 1'b1, 4'b0000, 1'b1, -1};
    for (int i = 0; i < 7; i++) begin
      tick(tbl[i].req, tbl[i].push);
      chk($sformatf("tbl%0d_gnt", i), 32'(s_gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_rd_en", i), 32'(s_rd_en), 32'(tbl[i].rd_en));
      chk($sformatf("tbl%0d_rd_valid", i), 32'(s_rd_valid), 32'(tbl[i].rd_valid));
      chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
      if (tbl[i].didx >= 0)
        chk($sformatf("tbl%0d_data", i), 32'(s_dat), 32'(base + DW'(tbl[i].didx)));
    end

    // Round robin under full demand: 0,1,2,3,0, four beats then one idle cycle each.
    do_reset();
    push(30);
    for (int c = 0; c < 25; c++) begin
      tick(4'b1111, 1);
      if (c == 0 || ((c - 1) % 5) == 4) exp_g = '0;
      else exp_g = ONE << (((c - 1) / 5) % NREQ);
      chk($sformatf("rr_c%0d_gnt", c), 32'(s_gnt), 32'(exp_g));
    end

    // Drain: two entries give exactly two reads, no regrant until a new write.
    flush();
    tick(4'b0000, 0);
    tick(4'b0000, 0);
    cnt_rd = 0;
    tick(4'b0001, 2);
    cnt_rd += int'(s_rd_en);
    for (int c = 0; c < 6; c++) begin
      tick(4'b0001, 0);
      cnt_rd += int'(s_rd_en);
    end
    chk("drain_reads", 32'(cnt_rd), 32'd2);
    chk("drain_idle_gnt", 32'(s_gnt), 32'd0);
    chk("drain_idle_busy", 32'(s_busy), 32'd0);
    tick(4'b0001, 1);
    chk("drain_write_cycle_gnt", 32'(s_gnt), 32'd0);
    tick(4'b0001, 0);
    chk("drain_regrant", 32'(s_gnt), 32'b0001);

    // Withdrawal: consumer 0 drops after one beat, consumer 1 wins next.
    do_reset();
    flush();
    cnt_v0 = 0;
    tick(4'b0011, 20);
    tick(4'b0011, 0);
    chk("wd_first_gnt", 32'(s_gnt), 32'b0001);
    chk("wd_first_rd", 32'(s_rd_en), 32'd1);
    tick(4'b0010, 0);
    chk("wd_drop_rd_en", 32'(s_rd_en), 32'd0);
    chk("wd_drop_valid", 32'(s_rd_valid), 32'b0001);
    cnt_v0 += int'(s_rd_valid[0]);
    tick(4'b0011, 0);
    chk("wd_idle_gnt", 32'(s_gnt), 32'd0);
    cnt_v0 += int'(s_rd_valid[0]);
    tick(4'b0011, 0);
    chk("wd_next_gnt", 32'(s_gnt), 32'b0010);
    cnt_v0 += int'(s_rd_valid[0]);
    chk("wd_c0_valid_count", 32'(cnt_v0), 32'd1);

    // Reset after two beats of consumer 1: pending strobe dropped, restart at consumer 0.
    tick(4'b0010, 0);
    chk("rmb_beat2", 32'(s_rd_en), 32'd1);
    do_reset();
    tick(4'b1111, 0);
    chk("rmb_no_valid", 32'(s_rd_valid), 32'd0);
    chk("rmb_idle_gnt", 32'(s_gnt), 32'd0);
    tick(4'b1111, 0);
    chk("rmb_restart_gnt", 32'(s_gnt), 32'b0001);

    // Random traffic against the model.
    cur_req = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) < 3) cur_req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if ($urandom_range(0, 99) < 2) flush();
      if ($urandom_range(0, 199) == 0) do_reset();
      tick(cur_req, ($urandom_range(0, 9) < 4) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Round-robin arbiter that shares the single read port of the synchronous FIFO among NREQ consumers. It grants one consumer at a time for a bounded burst of reads and drives the FIFO read-pointer's `rd` input. It returns read data to the granted consumer with a per-consumer valid strobe. It sits between the consumer blocks and the FIFO read side (read pointer plus synchronous-read memory).

## Interface
- NREQ, 4: number of consumers; legal range 2..8.
- DW, 8: FIFO data width.
- BURST, 4: maximum reads per grant; legal range 1..16.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NREQ  per-consumer read request; level-sensitive.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DW  FIFO memory read data; valid the cycle after an accepted read.
- fifo_rd_en  out  1  read strobe to the FIFO read pointer; combinational.
- gnt  out  NREQ  one-hot grant, registered; all zero when idle.
- rd_valid  out  NREQ  one-hot data strobe to the consumer owning rd_data this cycle; registered.
- rd_data  out  DW  equals fifo_dout; broadcast to all consumers.
- busy  out  1  high while in BURST.

## Operation
- The FSM has two states, IDLE and BURST.
- Internal state:
  - cnt: beat counter, width $clog2(BURST)+1.
  - last: index of the last granted consumer, width $clog2(NREQ).
  - gidx: index of the current grant.
- IDLE:
  - gnt=0 and fifo_rd_en=0.
  - If (|req) && !fifo_empty, the winner is the first asserted req scanning from (last+1) mod NREQ upward with wrap.
  - Next edge: gnt <= onehot(winner), gidx <= winner, cnt <= 0, state <= BURST.
  - Otherwise the block stays in IDLE.
- BURST:
  - fifo_rd_en = req[gidx] && !fifo_empty. The block never strobes the FIFO when it is empty.
  - Each edge with fifo_rd_en=1 increments cnt.
  - Exit to IDLE at the edge where any of these holds:
    - fifo_rd_en && cnt==BURST-1 (burst complete);
    - !req[gidx] (consumer withdrew);
    - fifo_empty (drained).
  - On exit: gnt <= 0, last <= gidx, cnt <= 0.
- Data return: rd_valid <= fifo_rd_en ? gnt : 0 on every edge. rd_data is the pass-through of fifo_dout, so it is valid when the rd_valid bit is set.
- rd_valid for the final beat asserts in the first IDLE cycle after the burst. Consumers must accept data regardless of their gnt.
- busy = (state==BURST).
- A req deasserting in the same cycle as a read cancels that read, because fifo_rd_en is combinational from req.
- Non-granted req changes have no effect until the next IDLE arbitration.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, gnt=0, rd_valid=0, busy=0, cnt=0, last=NREQ-1 (consumer 0 has first priority);
  - fifo_rd_en=0 because gnt=0.
- Grant latency: req with non-empty FIFO in cycle t gives gnt in cycle t+1 and the first fifo_rd_en in cycle t+1.
- Read latency: fifo_rd_en in cycle n gives rd_valid/rd_data in cycle n+1.
- Throughput: one read per cycle within a burst. The mandatory IDLE cycle between grants means at most BURST reads per BURST+1 cycles under continuous demand.
- Reset mid-burst:
  - gnt, busy and fifo_rd_en drop asynchronously.
  - A pending rd_valid is discarded.
  - After release, arbitration restarts at consumer 0.
- With fifo_empty high, no grant is issued and any active burst ends at the next edge.

## Test plan
- Reset check: assert rst_n=0 mid-activity. Required: gnt=0, rd_valid=0, fifo_rd_en=0, busy=0 immediately. After release with req=0001 and a non-empty FIFO, gnt=0001 on the next cycle.
- Single burst: BURST=4, FIFO preloaded with 10 entries, req=0001 from cycle 0.
  - gnt=0001 in cycles 1-4; fifo_rd_en high in cycles 1-4; rd_valid=0001 in cycles 2-5 carrying entries 0-3.
  - IDLE in cycle 5; regrant in cycle 6.
- Round-robin: req=1111 held, FIFO never empty. Required grant order 0,1,2,3,0, each grant 4 cycles followed by 1 idle cycle.
- Drain: FIFO holds 2 entries, req=0001. Required: 2 reads only, exit to IDLE after fifo_empty rises, no fifo_rd_en while empty, no regrant until a write occurs.
- Withdrawal: req=0011, consumer 0 drops req after its first read beat. Required:
  - rd_valid=0001 for that one beat;
  - consumer 0's grant ends at the edge after the drop;
  - the next grant goes to consumer 1, even though consumer 0 is requesting again.
- Reset mid-burst: reset after 2 of 4 beats. Required: no rd_valid after reset; arbitration restarts at consumer 0.
